instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the control unit: owns the PC, issues word reads to

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding word reads to imem and holds the
// returned instruction for decode. Optional perf counters under `ifdef FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_q,
  output logic [31:0] pc_plus4,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  input  logic        halt,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] wait_count
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    VALID  = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_cur_q, pc_cur_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic              ren_q, valid_q, halted_q;
  logic              accept;

  assign accept = (state_q == VALID) && instr_ready;

  // Next-state, next-PC and instruction capture
  always_comb begin
    state_d  = state_q;
    pc_cur_d = pc_cur_q;
    ir_d     = ir_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ihit) begin
          ir_d    = imemload;
          state_d = VALID;
        end
      end
      VALID: begin
        if (accept) begin
          // halt wins over a simultaneous redirect and freezes the PC
          if (halt) begin
            state_d = HALTED;
          end else if (redirect_en) begin
            pc_cur_d = redirect_addr & ~XLEN'(3);
            state_d  = REQ;
          end else begin
            pc_cur_d = pc_cur_q + XLEN'(4);
            state_d  = REQ;
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      pc_cur_q <= PC_INIT;
      ir_q     <= '0;
      ren_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_cur_q <= pc_cur_d;
      ir_q     <= ir_d;
      ren_q    <= (state_d == REQ);
      valid_q  <= (state_d == VALID);
      halted_q <= (state_d == HALTED);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, wait_cnt_q;

  // Counters naturally freeze in HALTED: neither accept nor REQ can occur there
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      end
      if ((state_q == REQ) && !ihit) begin
        wait_cnt_q <= wait_cnt_q + XLEN'(1);
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign wait_count  = wait_cnt_q;
`endif

  assign imemREN     = ren_q;
  assign imemaddr    = pc_cur_q;
  assign instr       = ir_q;
  assign instr_valid = valid_q;
  assign pc_q        = pc_cur_q;
  assign pc_plus4    = pc_cur_q + XLEN'(4);
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; second instance exercises PC wrap.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST, RST2;
  logic        imemREN, imemREN2;
  logic [31:0] imemaddr, imemaddr2;
  logic        ihit, ihit2;
  logic [31:0] imemload, imemload2;
  logic [31:0] instr, instr2;
  logic        instr_valid, instr_valid2;
  logic        instr_ready, instr_ready2;
  logic [31:0] pc_q, pc_q2;
  logic [31:0] pc_plus4, pc_plus4_2;
  logic        redirect_en, redirect_en2;
  logic [31:0] redirect_addr, redirect_addr2;
  logic        halt, halt2;
  logic        halted, halted2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, wait_count, fetch_count2, wait_count2;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_q(pc_q), .pc_plus4(pc_plus4),
    .redirect_en(redirect_en), .redirect_addr(redirect_addr), .halt(halt),
    .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .wait_count(wait_count)
`endif
  );

  instr_fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut2 (
    .CLK(CLK), .RST(RST2), .imemREN(imemREN2), .imemaddr(imemaddr2), .ihit(ihit2),
    .imemload(imemload2), .instr(instr2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .pc_q(pc_q2), .pc_plus4(pc_plus4_2),
    .redirect_en(redirect_en2), .redirect_addr(redirect_addr2), .halt(halt2),
    .halted(halted2)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count2), .wait_count(wait_count2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; ihit = 1'b1; instr_ready = 1'b1;
    step; step;
    total++; if (imemREN !== 1'b0) begin bad++; $display("FAIL rst_ren got=%b exp=0", imemREN); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (pc_q !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_q); end
    ihit = 1'b0; RST = 1'b0;
    step;
    total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%b exp=1", imemREN); end
    total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL rst_first_addr got=%h exp=0", imemaddr); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = 32'(i * 4);
      total++; if (imemREN !== 1'b1 || imemaddr !== exp) begin
        bad++; $display("FAIL b2b_req%0d got ren=%b addr=%h exp ren=1 addr=%h", i, imemREN, imemaddr, exp);
      end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_req_valid%0d got=%b exp=0", i, instr_valid); end
      imemload = 32'hA000_0000 + exp; ihit = 1'b1; instr_ready = 1'b1;
      step;
      total++; if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 + exp || imemREN !== 1'b0) begin
        bad++; $display("FAIL b2b_valid%0d got v=%b instr=%h ren=%b exp v=1 instr=%h ren=0", i, instr_valid, instr, imemREN, 32'hA000_0000 + exp);
      end
      total++; if (pc_q !== exp || pc_plus4 !== exp + 32'd4) begin
        bad++; $display("FAIL b2b_pc%0d got pc=%h p4=%h exp pc=%h p4=%h", i, pc_q, pc_plus4, exp, exp + 32'd4);
      end
      step;
    end
  endtask

  task automatic test_wait_states;
    ihit = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      total++; if (imemREN !== 1'b1 || imemaddr !== 32'h10 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL wait%0d got ren=%b addr=%h v=%b exp ren=1 addr=00000010 v=0", i, imemREN, imemaddr, instr_valid);
      end
    end
    imemload = 32'h2408_0005; ihit = 1'b1;
    step;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h2408_0005) begin
      bad++; $display("FAIL wait_capture got v=%b instr=%h exp v=1 instr=24080005", instr_valid, instr);
    end
  endtask

  task automatic test_hold;
    instr_ready = 1'b0; redirect_en = 1'b1; redirect_addr = 32'h100; halt = 1'b0;
    ihit = 1'b1; imemload = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (instr !== 32'h2408_0005 || pc_q !== 32'h10 || imemREN !== 1'b0 || instr_valid !== 1'b1) begin
        bad++; $display("FAIL hold%0d got instr=%h pc=%h ren=%b v=%b exp 24080005/00000010/0/1", i, instr, pc_q, imemREN, instr_valid);
      end
    end
  endtask

  task automatic test_redirect;
    ihit = 1'b0;
    total++; if (pc_plus4 !== 32'h14) begin bad++; $display("FAIL redir_p4 got=%h exp=00000014", pc_plus4); end
    redirect_en = 1'b1; redirect_addr = 32'h43; instr_ready = 1'b1;
    step;
    total++; if (imemREN !== 1'b1 || imemaddr !== 32'h40 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL redir_addr got ren=%b addr=%h v=%b exp 1/00000040/0", imemREN, imemaddr, instr_valid);
    end
    instr_ready = 1'b0; redirect_en = 1'b0; ihit = 1'b1; imemload = 32'h0000_000C;
    step;
    total++; if (pc_q !== 32'h40 || instr !== 32'h0000_000C) begin
      bad++; $display("FAIL redir_valid got pc=%h instr=%h exp 00000040/0000000c", pc_q, instr);
    end
  endtask

  task automatic test_halt;
    halt = 1'b1; redirect_en = 1'b1; redirect_addr = 32'h200; instr_ready = 1'b1;
    step;
    total++; if (halted !== 1'b1 || imemREN !== 1'b0 || instr_valid !== 1'b0 || pc_q !== 32'h40) begin
      bad++; $display("FAIL halt_enter got h=%b ren=%b v=%b pc=%h exp 1/0/0/00000040", halted, imemREN, instr_valid, pc_q);
    end
`ifdef FETCH_PERF_CNT_EN
    total++; if (fetch_count !== 32'd6 || wait_count !== 32'd3) begin
      bad++; $display("FAIL perf_cnt got f=%0d w=%0d exp 6/3", fetch_count, wait_count);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      ihit = i[0]; halt = ~i[0];
      step;
      total++; if (halted !== 1'b1 || imemREN !== 1'b0 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL halt_stay%0d got h=%b ren=%b v=%b exp 1/0/0", i, halted, imemREN, instr_valid);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    total++; if (fetch_count !== 32'd6 || wait_count !== 32'd3) begin
      bad++; $display("FAIL perf_freeze got f=%0d w=%0d exp 6/3", fetch_count, wait_count);
    end
`endif
    halt = 1'b0; redirect_en = 1'b0; instr_ready = 1'b0; ihit = 1'b0; RST = 1'b1;
    step;
    total++; if (halted !== 1'b0 || pc_q !== 32'h0) begin
      bad++; $display("FAIL halt_rst got h=%b pc=%h exp 0/00000000", halted, pc_q);
    end
    RST = 1'b0;
    step;
    total++; if (imemREN !== 1'b1 || imemaddr !== 32'h0) begin
      bad++; $display("FAIL halt_refetch got ren=%b addr=%h exp 1/00000000", imemREN, imemaddr);
    end
  endtask

  task automatic test_wrap_and_mid_reset;
    RST2 = 1'b0;
    step;
    total++; if (imemREN2 !== 1'b1 || imemaddr2 !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_init got ren=%b addr=%h exp 1/fffffffc", imemREN2, imemaddr2);
    end
    imemload2 = 32'h1234_5678; ihit2 = 1'b1;
    step;
    total++; if (pc_q2 !== 32'hFFFF_FFFC || pc_plus4_2 !== 32'h0) begin
      bad++; $display("FAIL wrap_p4 got pc=%h p4=%h exp fffffffc/00000000", pc_q2, pc_plus4_2);
    end
    instr_ready2 = 1'b1;
    step;
    total++; if (imemREN2 !== 1'b1 || imemaddr2 !== 32'h0) begin
      bad++; $display("FAIL wrap_next got ren=%b addr=%h exp 1/00000000", imemREN2, imemaddr2);
    end
    RST2 = 1'b1;
    step;
    total++; if (instr_valid2 !== 1'b0 || imemREN2 !== 1'b0) begin
      bad++; $display("FAIL midrst got v=%b ren=%b exp 0/0", instr_valid2, imemREN2);
    end
    RST2 = 1'b0; ihit2 = 1'b0;
    step;
    total++; if (instr_valid2 !== 1'b0 || imemREN2 !== 1'b1 || imemaddr2 !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL midrst_after got v=%b ren=%b addr=%h exp 0/1/fffffffc", instr_valid2, imemREN2, imemaddr2);
    end
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; instr_ready = 1'b0;
    redirect_en = 1'b0; redirect_addr = '0; halt = 1'b0;
    RST2 = 1'b1; ihit2 = 1'b0; imemload2 = '0; instr_ready2 = 1'b0;
    redirect_en2 = 1'b0; redirect_addr2 = '0; halt2 = 1'b0;
    test_reset;
    test_back_to_back;
    test_wait_states;
    test_hold;
    test_redirect;
    test_halt;
    test_wrap_and_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
